// File: rtl/wishbone_board_slave_if.sv
// Wishbone bus bundle between wishbone_master and the board RAM slave.
interface wishbone_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
);
  logic              cyc_i;
  logic              stb_i;
  logic              we_i;
  logic [ADDR_W-1:0] adr_i;
  logic [DATA_W-1:0] dat_i;
  logic [DATA_W-1:0] dat_o;
  logic              ack_o;
  logic              stall_o;

  modport slave  (input  cyc_i, stb_i, we_i, adr_i, dat_i,
                  output dat_o, ack_o, stall_o);
  modport master (output cyc_i, stb_i, we_i, adr_i, dat_i,
                  input  dat_o, ack_o, stall_o);
endinterface

// File: rtl/wishbone_board_slave.sv
// Pipelined Wishbone slave over the game-board RAM, with a renderer read port
// and a clear sweep that zeroes the board while the bus is stalled.
module wishbone_board_slave #(
  parameter int ADDR_W      = 8,
  parameter int DATA_W      = 8,
  parameter int DEPTH       = 256,
  parameter int WAIT_STATES = 0
) (
  input  logic              clk,
  input  logic              rst,
  wishbone_if.slave         wb_slave,
  input  logic              clear_req,
  output logic              clear_busy,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  localparam int                CTR_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CTR_W-1:0]  LAST      = CTR_W'(DEPTH - 1);
  localparam logic [ADDR_W:0]   DEPTH_L   = (ADDR_W + 1)'(DEPTH);
  localparam logic [3:0]        WAIT_INIT = 4'((WAIT_STATES > 0) ? WAIT_STATES - 1 : 0);

  typedef enum logic [1:0] {ST_CLEAR, ST_IDLE, ST_WAIT, ST_ACK} state_t;

  state_t            state, state_next;
  logic [CTR_W-1:0]  ctr, ctr_next;
  logic [3:0]        wcnt, wcnt_next;
  logic              latch, commit;

  logic [ADDR_W-1:0] adr_q;
  logic              we_q;
  logic [DATA_W-1:0] dat_q;
  logic [DATA_W-1:0] dat_out;

  logic [ADDR_W-1:0] txn_adr;
  logic              txn_we;
  logic [DATA_W-1:0] txn_dat;
  logic              txn_in_range;
  logic              rd_in_range;

  logic [DATA_W-1:0] mem [DEPTH];

  // The access is performed on the edge that enters ACK so that ack_o and
  // dat_o are both registered; with no wait states that edge is the accept
  // edge itself, so the live bus fields are used instead of the latched copy.
  always_comb begin
    txn_adr = (state == ST_IDLE) ? wb_slave.adr_i : adr_q;
    txn_we  = (state == ST_IDLE) ? wb_slave.we_i  : we_q;
    txn_dat = (state == ST_IDLE) ? wb_slave.dat_i : dat_q;
  end

  assign txn_in_range = ({1'b0, txn_adr} < DEPTH_L);
  assign rd_in_range  = ({1'b0, rd_addr} < DEPTH_L);

  always_comb begin
    state_next = state;
    ctr_next   = ctr;
    wcnt_next  = wcnt;
    latch      = 1'b0;
    commit     = 1'b0;
    case (state)
      ST_CLEAR: begin
        ctr_next = ctr + 1'b1;
        if (clear_req) begin
          ctr_next = '0;
        end else if (ctr == LAST) begin
          state_next = ST_IDLE;
          ctr_next   = '0;
        end
      end
      ST_IDLE: begin
        if (clear_req) begin
          state_next = ST_CLEAR;
          ctr_next   = '0;
        end else if (wb_slave.cyc_i && wb_slave.stb_i) begin
          latch = 1'b1;
          if (WAIT_STATES == 0) begin
            state_next = ST_ACK;
            commit     = 1'b1;
          end else begin
            state_next = ST_WAIT;
            wcnt_next  = WAIT_INIT;
          end
        end
      end
      ST_WAIT: begin
        if (clear_req) begin
          state_next = ST_CLEAR;
          ctr_next   = '0;
        end else if (!wb_slave.cyc_i) begin
          state_next = ST_IDLE;
        end else if (wcnt == 4'd0) begin
          state_next = ST_ACK;
          commit     = 1'b1;
        end else begin
          wcnt_next = wcnt - 1'b1;
        end
      end
      ST_ACK: begin
        if (clear_req) begin
          state_next = ST_CLEAR;
          ctr_next   = '0;
        end else begin
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_CLEAR;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_CLEAR;
      ctr     <= '0;
      wcnt    <= '0;
      adr_q   <= '0;
      we_q    <= 1'b0;
      dat_q   <= '0;
      dat_out <= '0;
      rd_data <= '0;
    end else begin
      state <= state_next;
      ctr   <= ctr_next;
      wcnt  <= wcnt_next;
      if (latch) begin
        adr_q <= wb_slave.adr_i;
        we_q  <= wb_slave.we_i;
        dat_q <= wb_slave.dat_i;
      end
      if (commit && !txn_we)
        dat_out <= txn_in_range ? mem[txn_adr] : '0;
      rd_data <= rd_in_range ? mem[rd_addr] : '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state == ST_CLEAR)
        mem[ctr] <= '0;
      else if (commit && txn_we && txn_in_range)
        mem[txn_adr] <= txn_dat;
    end
  end

  assign wb_slave.dat_o   = dat_out;
  assign wb_slave.ack_o   = (state == ST_ACK);
  assign wb_slave.stall_o = (state != ST_IDLE);
  assign clear_busy       = (state == ST_CLEAR);

endmodule

// File: tb/tb_wishbone_board_slave.sv
// Two slaves (no wait states / full depth, three wait states / short depth)
// driven with directed and random traffic against an array model of the board.
module tb_wishbone_board_slave;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int ws    [2] = '{0, 3};
  int depth [2] = '{256, 200};

  logic [1:0] cyc = '0, stb = '0, we_v = '0, clr = '0;
  logic [7:0] adr [2];
  logic [7:0] dat [2];
  logic [7:0] ra  [2];

  wire  [1:0] ack, stall, busy;
  wire  [7:0] dato [2];
  wire  [7:0] rdd  [2];

  wishbone_if #(.ADDR_W(8), .DATA_W(8)) bus0 ();
  wishbone_if #(.ADDR_W(8), .DATA_W(8)) bus1 ();

  assign bus0.cyc_i = cyc[0];  assign bus1.cyc_i = cyc[1];
  assign bus0.stb_i = stb[0];  assign bus1.stb_i = stb[1];
  assign bus0.we_i  = we_v[0]; assign bus1.we_i  = we_v[1];
  assign bus0.adr_i = adr[0];  assign bus1.adr_i = adr[1];
  assign bus0.dat_i = dat[0];  assign bus1.dat_i = dat[1];
  assign ack   = {bus1.ack_o, bus0.ack_o};
  assign stall = {bus1.stall_o, bus0.stall_o};
  assign dato[0] = bus0.dat_o;
  assign dato[1] = bus1.dat_o;

  wishbone_board_slave #(.ADDR_W(8), .DATA_W(8), .DEPTH(256), .WAIT_STATES(0)) dut0 (
    .clk(clk), .rst(rst), .wb_slave(bus0.slave), .clear_req(clr[0]),
    .clear_busy(busy[0]), .rd_addr(ra[0]), .rd_data(rdd[0]));

  wishbone_board_slave #(.ADDR_W(8), .DATA_W(8), .DEPTH(200), .WAIT_STATES(3)) dut1 (
    .clk(clk), .rst(rst), .wb_slave(bus1.slave), .clear_req(clr[1]),
    .clear_busy(busy[1]), .rd_addr(ra[1]), .rd_data(rdd[1]));

  logic [7:0] model   [2][256];
  logic [7:0] last_rd [2];
  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] model_rd(input int d, input logic [7:0] a);
    return (int'(a) < depth[d]) ? model[d][a] : 8'h00;
  endfunction

  task automatic model_clear(input int d);
    for (int i = 0; i < 256; i++) model[d][i] = 8'h00;
  endtask

  // Counts negedges until clear_busy falls on each slave; stall must follow it.
  task automatic measure_busy(input string tag);
    int done [2];
    done = '{-1, -1};
    for (int n = 0; n < 600; n++) begin
      for (int d = 0; d < 2; d++) begin
        if (done[d] < 0) begin
          check({tag, "_stall"}, stall[d], (n < depth[d]) ? 1 : 0);
          if (!busy[d]) done[d] = n;
        end
      end
      if (done[0] >= 0 && done[1] >= 0) break;
      @(negedge clk);
    end
    for (int d = 0; d < 2; d++) check({tag, "_busy_len"}, done[d], depth[d]);
  endtask

  task automatic wb_op(input int d, input bit wr, input logic [7:0] a, input logic [7:0] v);
    int  k;
    bit  seen;
    @(negedge clk);
    check("idle_stall", stall[d], 0);
    cyc[d] = 1'b1; stb[d] = 1'b1; we_v[d] = wr; adr[d] = a; dat[d] = v;
    @(posedge clk); #1;
    stb[d] = 1'b0;
    seen = 0; k = 0;
    while (!seen && k < 40) begin
      @(negedge clk);
      k++;
      if (ack[d]) seen = 1;
      else check("wait_stall", stall[d], 1);
    end
    check("ack_latency", k, ws[d] + 1);
    if (seen) begin
      check("ack_stall", stall[d], 1);
      if (!wr) begin
        last_rd[d] = model_rd(d, a);
        check("rd_dat_o", dato[d], last_rd[d]);
      end else begin
        if (int'(a) < depth[d]) model[d][a] = v;
        check("wr_holds_dat_o", dato[d], last_rd[d]);
      end
    end
    @(posedge clk); #1;
    cyc[d] = 1'b0;
    @(negedge clk);
    check("ack_one_cycle", ack[d], 0);
    check("stall_release", stall[d], 0);
  endtask

  initial begin
    for (int d = 0; d < 2; d++) begin
      adr[d] = '0; dat[d] = '0; ra[d] = 8'h10; last_rd[d] = '0;
      model_clear(d);
    end

    // Reset held for 10 clocks, then the power-on sweep.
    repeat (10) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      check("rst_ack", ack[d], 0);
      check("rst_stall", stall[d], 1);
      check("rst_dat_o", dato[d], 0);
      check("rst_rd_data", rdd[d], 0);
      check("rst_busy", busy[d], 1);
    end
    rst = 1'b0;
    measure_busy("sweep");
    @(negedge clk);
    for (int d = 0; d < 2; d++) check("rd_after_sweep", rdd[d], 0);

    // Write then read at 0x80 on both slaves.
    for (int d = 0; d < 2; d++) begin
      wb_op(d, 1'b1, 8'h80, 8'hAA);
      wb_op(d, 1'b0, 8'h80, 8'h00);
    end

    // Abort by dropping cyc during the wait states: no ack, no write.
    @(negedge clk);
    cyc[1] = 1'b1; stb[1] = 1'b1; we_v[1] = 1'b1; adr[1] = 8'h10; dat[1] = 8'h55;
    @(posedge clk); #1;
    stb[1] = 1'b0;
    @(negedge clk);
    check("abort_stall", stall[1], 1);
    cyc[1] = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("abort_no_ack", ack[1], 0);
    end
    check("abort_idle", stall[1], 0);
    wb_op(1, 1'b0, 8'h10, 8'h00);

    // Renderer port reads old data in the cycle the bus write lands.
    @(negedge clk);
    ra[0] = 8'h80;
    cyc[0] = 1'b1; stb[0] = 1'b1; we_v[0] = 1'b1; adr[0] = 8'h80; dat[0] = 8'h33;
    @(posedge clk); #1;
    stb[0] = 1'b0;
    @(negedge clk);
    check("rbw_ack", ack[0], 1);
    check("rbw_old", rdd[0], 8'hAA);
    @(posedge clk); #1;
    cyc[0] = 1'b0;
    model[0][8'h80] = 8'h33;
    @(negedge clk);
    check("rbw_new", rdd[0], 8'h33);

    // Random traffic, concentrated around the short slave's depth boundary.
    for (int i = 0; i < 60; i++) begin
      int d;
      logic [7:0] a;
      d = int'($urandom_range(0, 1));
      a = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(190, 209));
      wb_op(d, 1'($urandom_range(0, 1)), a, 8'($urandom));
      if ($urandom_range(0, 2) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
    end
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) ra[d] = 8'($urandom_range(185, 215));
      @(negedge clk);
      for (int d = 0; d < 2; d++) check("rand_rd_data", rdd[d], model_rd(d, ra[d]));
    end

    // New game: clear sweep, then every cell reads zero and dat_o is untouched.
    @(negedge clk);
    clr = 2'b11;
    @(negedge clk);
    clr = 2'b00;
    measure_busy("clear");
    for (int d = 0; d < 2; d++) begin
      model_clear(d);
      check("clear_dat_o", dato[d], last_rd[d]);
    end
    for (int a = 0; a < 256; a++) begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) ra[d] = 8'(a);
      @(negedge clk);
      for (int d = 0; d < 2; d++) check("clear_rd_data", rdd[d], model_rd(d, ra[d]));
    end
    wb_op(0, 1'b0, 8'h80, 8'h00);
    wb_op(1, 1'b0, 8'hC5, 8'h00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
